// File: rtl/sm_arith_pkg.sv
// Shared encodings, FSM states and sign-magnitude <-> two's-complement helpers
// for the sign-magnitude arithmetic unit.
package sm_arith_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Wide enough for any supported operand width; callers zero-extend and truncate.
  localparam int unsigned TcW = 32;

  function automatic logic [TcW-1:0] sm_to_tc(input logic sign, input logic [TcW-1:0] mag);
    return sign ? (~mag + TcW'(1)) : mag;
  endfunction

  function automatic logic [TcW-1:0] tc_abs(input logic [TcW-1:0] val);
    return val[TcW-1] ? (~val + TcW'(1)) : val;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex nibble to 7-segment glyph; bit6..bit0 = segments a..g, active high.
module seg7_hex (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    unique case (nibble_i)
      4'h0: seg_o = 7'b1111110;
      4'h1: seg_o = 7'b0110000;
      4'h2: seg_o = 7'b1101101;
      4'h3: seg_o = 7'b1111001;
      4'h4: seg_o = 7'b0110011;
      4'h5: seg_o = 7'b1011011;
      4'h6: seg_o = 7'b1011111;
      4'h7: seg_o = 7'b1110000;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1111011;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b0011111;
      4'hC: seg_o = 7'b1001110;
      4'hD: seg_o = 7'b0111101;
      4'hE: seg_o = 7'b1001111;
      4'hF: seg_o = 7'b1000111;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/sm_arith_unit.sv
// Sequential sign-magnitude ADD/SUB/MUL/PASS unit with start/busy/done handshake
// and a hex 7-segment view of the registered result.
module sm_arith_unit
  import sm_arith_pkg::*;
#(
  parameter int unsigned W      = 5,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          a_sm,
  input  logic [W-1:0]          b_sm,
  input  logic [1:0]            op,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  res_sign,
  output logic [2*(W-1)-1:0]    res_mag,
  output logic [7*DIGITS-1:0]   display
);

  localparam int unsigned MW   = W - 1;
  localparam int unsigned RW   = 2 * MW;
  localparam int unsigned ND   = (RW + 3) / 4;
  localparam int unsigned CW   = (MW > 1) ? $clog2(MW) : 1;
  localparam int unsigned NibW = 4 * ND;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic            a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic [MW-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic            res_sign_q, res_sign_d;
  logic [RW-1:0]   res_mag_q, res_mag_d;

  // Negative zero on an input collapses to +0 here.
  logic            a_neg, b_neg;
  logic [TcW-1:0]  a_tc, b_tc, lin_tc;
  logic            lin_sign;
  logic [RW-1:0]   lin_mag;

  assign a_neg = a_sm[W-1] & (|a_sm[MW-1:0]);
  assign b_neg = b_sm[W-1] & (|b_sm[MW-1:0]);

  always_comb begin
    a_tc = sm_to_tc(a_neg, TcW'(a_sm[MW-1:0]));
    b_tc = sm_to_tc(b_neg, TcW'(b_sm[MW-1:0]));
    case (op)
      OP_SUB:  lin_tc = a_tc - b_tc;
      OP_PASS: lin_tc = a_tc;
      default: lin_tc = a_tc + b_tc;
    endcase
    // A negative two's-complement value is never zero, so zero results come out positive.
    lin_sign = lin_tc[TcW-1];
    lin_mag  = RW'(tc_abs(lin_tc));
  end

  logic [RW-1:0] pp, acc_sum;
  logic          mul_last;

  assign pp       = b_mag_q[cnt_q] ? (RW'(a_mag_q) << cnt_q) : '0;
  assign acc_sum  = acc_q + pp;
  assign mul_last = (cnt_q == CW'(MW - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_sign_d   = a_sign_q;
    a_mag_d    = a_mag_q;
    b_sign_d   = b_sign_q;
    b_mag_d    = b_mag_q;
    res_sign_d = res_sign_q;
    res_mag_d  = res_mag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sign_d = a_neg;
          a_mag_d  = a_sm[MW-1:0];
          b_sign_d = b_neg;
          b_mag_d  = b_sm[MW-1:0];
          if (op == OP_MUL) begin
            state_d = ST_MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d    = ST_FIN;
            res_sign_d = lin_sign;
            res_mag_d  = lin_mag;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        // Partial products stay in acc_q; res_* only sees the final product.
        if (mul_last) begin
          state_d    = ST_FIN;
          cnt_d      = '0;
          res_mag_d  = acc_sum;
          res_sign_d = (a_sign_q ^ b_sign_q) & (|acc_sum);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      a_sign_q   <= 1'b0;
      a_mag_q    <= '0;
      b_sign_q   <= 1'b0;
      b_mag_q    <= '0;
      res_sign_q <= 1'b0;
      res_mag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_sign_q   <= a_sign_d;
      a_mag_q    <= a_mag_d;
      b_sign_q   <= b_sign_d;
      b_mag_q    <= b_mag_d;
      res_sign_q <= res_sign_d;
      res_mag_q  <= res_mag_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign res_sign = res_sign_q;
  assign res_mag  = res_mag_q;

  logic [NibW-1:0] mag_nib;
  assign mag_nib = NibW'(res_mag_q);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i < ND) begin : g_hex
      seg7_hex u_seg7_hex (
        .nibble_i (mag_nib[4*i+3:4*i]),
        .seg_o    (display[7*i+6:7*i])
      );
    end else if (i == ND) begin : g_sign
      assign display[7*i+6:7*i] = (res_sign_q && (res_mag_q != '0)) ? SEG_MINUS : SEG_BLANK;
    end else begin : g_blank
      assign display[7*i+6:7*i] = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_sm_arith_unit.sv
// Directed self-checking bench for sm_arith_unit at W=5, DIGITS=6.
module tb_sm_arith_unit;

  localparam int unsigned W      = 5;
  localparam int unsigned DIGITS = 6;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a_sm, b_sm;
  logic [1:0]  op;
  logic        start;
  logic        busy, done, res_sign;
  logic [7:0]  res_mag;
  logic [41:0] display;

  int checks;
  int failures;

  // Digit glyphs, a..g on bits 6..0.
  localparam logic [6:0] G0 = 7'h7E;
  localparam logic [6:0] G1 = 7'h30;
  localparam logic [6:0] G2 = 7'h6D;
  localparam logic [6:0] G6 = 7'h5F;
  localparam logic [6:0] G9 = 7'h7B;
  localparam logic [6:0] GE = 7'h4F;
  localparam logic [6:0] GF = 7'h47;
  localparam logic [6:0] GM = 7'h01;
  localparam logic [6:0] GB = 7'h00;

  sm_arith_unit #(
    .W      (W),
    .DIGITS (DIGITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_sm     (a_sm),
    .b_sm     (b_sm),
    .op       (op),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_sign (res_sign),
    .res_mag  (res_mag),
    .display  (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request before the next rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
    @(negedge clk);
    a_sm  = a;
    b_sm  = b;
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [41:0] exp_disp;
    exp_disp = {GB, GB, GB, GB, G0, G0};
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({res_sign, res_mag} !== 9'h000) begin failures++;
      $display("FAIL reset_res got=%b/%h exp=0/00", res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL reset_display got=%h exp=%h", display, exp_disp); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [41:0] exp_disp;
    exp_disp = {GB, GB, GB, GM, G0, G2};
    issue(5'b00011, 5'b10101, 2'b00);
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++;
      $display("FAIL add_done got=%b/%b exp=1/1", done, busy); end
    checks++; if ({res_sign, res_mag} !== {1'b1, 8'h02}) begin failures++;
      $display("FAIL add_res got=%b/%h exp=1/02", res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL add_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || res_mag !== 8'h02) begin failures++;
      $display("FAIL add_hold got=%b/%b/%h exp=0/0/02", done, busy, res_mag); end
  endtask

  task automatic test_sub;
    logic [41:0] exp_disp;
    issue(5'b10000, 5'b10000, 2'b01);
    exp_disp = {GB, GB, GB, GB, G0, G0};
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h00}) begin failures++;
      $display("FAIL sub_negzero got=%b/%b/%h exp=1/0/00", done, res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL sub_negzero_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
    issue(5'b00111, 5'b11000, 2'b01);
    exp_disp = {GB, GB, GB, GB, G0, GF};
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h0F}) begin failures++;
      $display("FAIL sub_max got=%b/%b/%h exp=1/0/0f", done, res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL sub_max_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [41:0] exp_disp;
    exp_disp = {GB, GB, GB, GM, GE, G1};
    issue(5'b11111, 5'b01111, 2'b10);
    for (int c = 0; c < 4; c++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++;
        $display("FAIL mul_busy c=%0d got=%b/%b exp=1/0", c, busy, done); end
      checks++; if ({res_sign, res_mag} !== {1'b0, 8'h0F}) begin failures++;
        $display("FAIL mul_hold c=%0d got=%b/%h exp=0/0f", c, res_sign, res_mag); end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++;
      $display("FAIL mul_done got=%b/%b exp=1/1", done, busy); end
    checks++; if ({res_sign, res_mag} !== {1'b1, 8'hE1}) begin failures++;
      $display("FAIL mul_res got=%b/%h exp=1/e1", res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL mul_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL mul_after got=%b/%b exp=0/0", done, busy); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    ndone = 0;
    @(negedge clk);
    a_sm = 5'b00011; b_sm = 5'b00010; op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    a_sm = 5'b01111; b_sm = 5'b01111;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
      if (c == 4) begin
        checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h06}) begin failures++;
          $display("FAIL b2b_first got=%b/%b/%h exp=1/0/06", done, res_sign, res_mag); end
      end
    end
    checks++; if (ndone != 1) begin failures++;
      $display("FAIL b2b_pulses got=%0d exp=1", ndone); end
    checks++; if (busy !== 1'b0 || res_mag !== 8'h06) begin failures++;
      $display("FAIL b2b_idle got=%b/%h exp=0/06", busy, res_mag); end
    a_sm = 5'b00001; b_sm = 5'b00001; op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h02}) begin failures++;
      $display("FAIL b2b_next got=%b/%b/%h exp=1/0/02", done, res_sign, res_mag); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [41:0] exp_disp;
    int ndone;
    ndone = 0;
    exp_disp = {GB, GB, GB, GB, G0, G0};
    issue(5'b11111, 5'b01111, 2'b10);
    @(posedge clk); #1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL rstmid_busy got=%b/%b exp=0/0", busy, done); end
    checks++; if ({res_sign, res_mag} !== 9'h000) begin failures++;
      $display("FAIL rstmid_res got=%b/%h exp=0/00", res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL rstmid_display got=%h exp=%h", display, exp_disp); end
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++;
      $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_zero_pass;
    logic [41:0] exp_disp;
    exp_disp = {GB, GB, GB, GM, G0, G9};
    issue(5'b11001, 5'b00000, 2'b11);
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b1, 8'h09}) begin failures++;
      $display("FAIL pass got=%b/%b/%h exp=1/1/09", done, res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL pass_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
    issue(5'b00011, 5'b10011, 2'b00);
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h00}) begin failures++;
      $display("FAIL add_cancel got=%b/%b/%h exp=1/0/00", done, res_sign, res_mag); end
    @(posedge clk); #1;
    issue(5'b11001, 5'b00000, 2'b11);
    @(posedge clk); #1;
    issue(5'b10110, 5'b00000, 2'b10);
    repeat (4) begin
      @(posedge clk); #1;
    end
    exp_disp = {GB, GB, GB, GB, G0, G0};
    checks++; if ({done, res_sign, res_mag} !== {1'b1, 1'b0, 8'h00}) begin failures++;
      $display("FAIL mul_zero got=%b/%b/%h exp=1/0/00", done, res_sign, res_mag); end
    checks++; if (display !== exp_disp) begin failures++;
      $display("FAIL mul_zero_display got=%h exp=%h", display, exp_disp); end
    @(posedge clk); #1;
    issue(5'b10110, 5'b00001, 2'b10);
    repeat (4) begin
      @(posedge clk); #1;
    end
    exp_disp = {GB, GB, GB, GM, G0, G6};
    checks++; if ({done, res_sign, res_mag, display} !== {1'b1, 1'b1, 8'h06, exp_disp}) begin
      failures++;
      $display("FAIL mul_neg got=%b/%b/%h/%h exp=1/1/06/%h", done, res_sign, res_mag, display,
               exp_disp); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_sm     = '0;
    b_sm     = '0;
    op       = '0;
    start    = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    test_zero_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
